// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light scheduler: state encodings,
// lamp colour codes and the state-to-lamp decode helpers.
package traffic_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    A_GRN = 3'd1,
    A_YEL = 3'd2,
    A_CLR = 3'd3,
    B_GRN = 3'd4,
    B_YEL = 3'd5,
    B_CLR = 3'd6,
    FLASH = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OFF = 2'd0,
    RED = 2'd1,
    YEL = 2'd2,
    GRN = 2'd3
  } colour_t;

  // Lamp pins are ordered {r, g, b}; blue is never lit.
  function automatic logic [2:0] colour_rgb(colour_t c);
    case (c)
      RED:     return 3'b100;
      YEL:     return 3'b110;
      GRN:     return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic colour_t lamp_a(state_t s);
    case (s)
      A_GRN:                      return GRN;
      A_YEL:                      return YEL;
      A_CLR, B_GRN, B_YEL, B_CLR: return RED;
      default:                    return OFF;
    endcase
  endfunction

  function automatic colour_t lamp_b(state_t s);
    case (s)
      B_GRN:                      return GRN;
      B_YEL:                      return YEL;
      A_GRN, A_YEL, A_CLR, B_CLR: return RED;
      default:                    return OFF;
    endcase
  endfunction

  // Successor in the phase ring; IDLE joins the ring at A_GRN.
  function automatic state_t ring_next(state_t s);
    case (s)
      IDLE:    return A_GRN;
      A_GRN:   return A_YEL;
      A_YEL:   return A_CLR;
      A_CLR:   return B_GRN;
      B_GRN:   return B_YEL;
      B_YEL:   return B_CLR;
      B_CLR:   return A_GRN;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV clocks.
module tick_gen #(
  parameter int unsigned TICK_DIV = 125000000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else if (tick) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/traffic_light_scheduler.sv
// Two-direction intersection scheduler cycling green/yellow/all-red per tick.
// Build with FLASH_MODE_EN to add the flash input and flashing-yellow state.
module traffic_light_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 125000000,
  parameter int unsigned GREEN_SEC  = 5,
  parameter int unsigned SHORT_SEC  = 2,
  parameter int unsigned YELLOW_SEC = 1,
  parameter int unsigned ALLRED_SEC = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
`ifdef FLASH_MODE_EN
  input  logic       flash,
`endif
  output logic       led4_r,
  output logic       led4_g,
  output logic       led4_b,
  output logic       led5_r,
  output logic       led5_g,
  output logic       led5_b,
  output logic [2:0] phase,
  output logic [3:0] sec_left
);

  localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_SEC - 1);
  localparam logic [3:0] SHORT_LOAD  = 4'(SHORT_SEC - 1);
  localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_SEC - 1);
  localparam logic [3:0] ALLRED_LOAD = 4'(ALLRED_SEC - 1);

  function automatic logic [3:0] load_for(state_t s);
    case (s)
      A_GRN, B_GRN: return GREEN_LOAD;
      A_YEL, B_YEL: return YELLOW_LOAD;
      A_CLR, B_CLR: return ALLRED_LOAD;
      default:      return 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] lamps_for(state_t s);
    return {colour_rgb(lamp_a(s)), colour_rgb(lamp_b(s))};
  endfunction

  logic       tick;
  state_t     state_reg;
  logic [3:0] timer_reg;
  logic       pend_a_reg;
  logic       pend_b_reg;
  logic [5:0] lamps_reg;

  state_t     ring_state;
  logic       move;
  logic       take_a;
  logic       take_b;
  logic       enter_a;
  logic       enter_b;
  logic       clamp;

`ifdef FLASH_MODE_EN
  localparam logic [5:0] FLASH_LAMPS = {colour_rgb(YEL), colour_rgb(YEL)};
  logic flash_lit_reg;
`endif

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign ring_state = ring_next(state_reg);
  assign move       = tick && (timer_reg == 4'd0);
  assign take_a     = req_a && (state_reg != A_GRN);
  assign take_b     = req_b && (state_reg != B_GRN);
  assign enter_a    = move && (ring_state == A_GRN);
  assign enter_b    = move && (ring_state == B_GRN);

  // A request arriving this cycle already counts, so the clamp lands on the next edge.
  assign clamp = (timer_reg > SHORT_LOAD) &&
                 (((state_reg == A_GRN) && (pend_b_reg || take_b)) ||
                  ((state_reg == B_GRN) && (pend_a_reg || take_a)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      timer_reg     <= 4'd0;
      pend_a_reg    <= 1'b0;
      pend_b_reg    <= 1'b0;
      lamps_reg     <= 6'd0;
`ifdef FLASH_MODE_EN
      flash_lit_reg <= 1'b0;
`endif
    end else begin
`ifdef FLASH_MODE_EN
      if (flash) begin
        state_reg  <= FLASH;
        timer_reg  <= 4'd0;
        pend_a_reg <= 1'b0;
        pend_b_reg <= 1'b0;
        if (state_reg != FLASH) begin
          flash_lit_reg <= 1'b1;
          lamps_reg     <= FLASH_LAMPS;
        end else if (tick) begin
          flash_lit_reg <= ~flash_lit_reg;
          lamps_reg     <= flash_lit_reg ? 6'd0 : FLASH_LAMPS;
        end
      end else if (state_reg == FLASH) begin
        state_reg  <= A_CLR;
        timer_reg  <= ALLRED_LOAD;
        pend_a_reg <= 1'b0;
        pend_b_reg <= 1'b0;
        lamps_reg  <= lamps_for(A_CLR);
      end else
`endif
      begin
        // Only reachable by upset when the flash state is not built in.
        if (state_reg == FLASH) begin
          state_reg <= IDLE;
          timer_reg <= 4'd0;
          lamps_reg <= 6'd0;
        end else if (move) begin
          state_reg <= ring_state;
          timer_reg <= load_for(ring_state);
          lamps_reg <= lamps_for(ring_state);
        end else if (clamp) begin
          timer_reg <= SHORT_LOAD;
        end else if (tick) begin
          timer_reg <= timer_reg - 4'd1;
        end

        pend_a_reg <= enter_a ? 1'b0 : (pend_a_reg | take_a);
        pend_b_reg <= enter_b ? 1'b0 : (pend_b_reg | take_b);
      end
    end
  end

  assign {led4_r, led4_g, led4_b, led5_r, led5_g, led5_b} = lamps_reg;
  assign phase    = state_reg;
  assign sec_left = timer_reg;

endmodule
